// File: rtl/addsub_pkg.sv
// addsub_pkg: op codes, flag payload and saturation bounds for addsub_pipe_sat
package addsub_pkg;
  typedef enum logic [1:0] {
    OP_ADD      = 2'b00,
    OP_SUB      = 2'b01,
    OP_ACC      = 2'b10,
    OP_ACC_LOAD = 2'b11
  } op_e;
  typedef struct packed {
    logic ovf;
    logic carry;
  } flags_t;
  localparam int MAX_N = 64;
  function automatic logic [MAX_N-1:0] sat_max(input int n);
    return (MAX_N'(1) << (n - 1)) - MAX_N'(1);
  endfunction
  function automatic logic [MAX_N-1:0] sat_min(input int n);
    return ~sat_max(n);
  endfunction
endpackage

// File: rtl/addsub_pipe_sat_if.sv
// addsub_pipe_sat_if: operand/result handshake bundle (in_valid/in_ready/op/a/b in, out_valid/out_ready/result/ovf/carry out)
interface addsub_pipe_sat_if #(parameter int N = 32);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         ovf;
  logic         carry;
  modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, result, ovf, carry);
  modport slave (input in_valid, op, a, b, out_ready, output in_ready, out_valid, result, ovf, carry);
endinterface

// File: rtl/addsub_pipe_sat_pipe_stage.sv
// pipe_stage: one elastic register stage; up_* from previous stage, dn_* toward consumer
module pipe_stage #(parameter type T = logic) (
  input  logic clk,
  input  logic reset_n,
  input  logic up_valid_i,
  output logic up_ready_o,
  input  T     up_data_i,
  output logic dn_valid_o,
  input  logic dn_ready_i,
  output T     dn_data_o
);
  logic vld_q;
  T     data_q;
  assign up_ready_o = !vld_q || dn_ready_i;
  assign dn_valid_o = vld_q;
  assign dn_data_o  = data_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (up_ready_o) begin
      vld_q <= up_valid_i;
      if (up_valid_i) data_q <= up_data_i;
    end
endmodule

// File: rtl/addsub_pipe_sat.sv
// addsub_pipe_sat: pipelined signed add/sub/accumulate with optional saturation; ports clk, reset_n, bus_io (slave handshake bundle)
module addsub_pipe_sat
  import addsub_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 2,
  parameter bit SAT    = 1
) (
  input logic clk,
  input logic reset_n,
  addsub_pipe_sat_if.slave bus_io
);
  typedef struct packed {
    logic [N-1:0] result;
    flags_t       fl;
  } stage_t;
  localparam logic [N-1:0] SMAX = N'(sat_max(N));
  localparam logic [N-1:0] SMIN = N'(sat_min(N));
  op_e              op;
  logic             sub, ld, acc_op, ovf_raw, accept;
  logic [N-1:0]     x, y, acc_q, acc_d;
  logic [N:0]       ext;
  stage_t           res, p1_q;
  logic             v1_q;
  logic [STAGES:1]  vld;
  stage_t [STAGES:1] pl;
  logic [STAGES+1:1] rdy;
  always_comb begin
    op      = op_e'(bus_io.op);
    sub     = op == OP_SUB;
    ld      = op == OP_ACC_LOAD;
    acc_op  = op == OP_ACC;
    x       = acc_op ? acc_q : bus_io.a;
    y       = acc_op ? bus_io.a : bus_io.b;
    ext     = sub ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
    // operand signs must match for ADD/ACC and differ for SUB before the result sign can flip
    ovf_raw = !ld && ((x[N-1] ^ y[N-1]) == sub) && (ext[N-1] != x[N-1]);
    // on overflow the true result carries the sign of x
    res.result   = ld ? bus_io.a : (SAT && ovf_raw) ? (x[N-1] ? SMIN : SMAX) : ext[N-1:0];
    res.fl.ovf   = ovf_raw;
    res.fl.carry = !ld && ext[N];
    accept  = bus_io.in_valid && rdy[1];
    acc_d   = (accept && (acc_op || ld)) ? res.result : acc_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v1_q  <= 1'b0;
      p1_q  <= '0;
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (rdy[1]) v1_q <= bus_io.in_valid;
      if (accept) p1_q <= res;
    end
  assign rdy[STAGES+1]    = bus_io.out_ready;
  assign rdy[1]           = !v1_q || rdy[2];
  assign vld[1]           = v1_q;
  assign pl[1]            = p1_q;
  assign bus_io.in_ready  = rdy[1];
  assign bus_io.out_valid = vld[STAGES];
  assign bus_io.result    = pl[STAGES].result;
  assign bus_io.ovf       = pl[STAGES].fl.ovf;
  assign bus_io.carry     = pl[STAGES].fl.carry;
  for (genvar k = 2; k <= STAGES; k++) begin : g_stage
    pipe_stage #(.T(stage_t)) u_stage (
      .clk        (clk),
      .reset_n    (reset_n),
      .up_valid_i (vld[k-1]),
      .up_ready_o (rdy[k]),
      .up_data_i  (pl[k-1]),
      .dn_valid_o (vld[k]),
      .dn_ready_i (rdy[k+1]),
      .dn_data_o  (pl[k])
    );
  end
endmodule

// File: tb/tb_addsub_pipe_sat.sv
// tb_addsub_pipe_sat: directed self-checking bench for addsub_pipe_sat
module tb_addsub_pipe_sat;
  import addsub_pkg::*;
  typedef struct {
    logic [31:0] r;
    logic        o;
    logic        c;
    int          t;
  } rec_t;
  localparam int STG [4] = '{2, 2, 1, 4};
  localparam bit SATV [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic clk = 0, reset_n = 1, in_valid = 0, out_ready = 1, bp_on = 0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 0, b = 0;
  logic [3:0]  en = 4'b0001, rdy_v, ov, ofl, cyl;
  logic [3:0]  pat = 4'b1001;
  logic [31:0] rv [4];
  rec_t q [4][$];
  int cyc = 0, total = 0, bad = 0, last_acc = 0, occ = 0, ph = 0, t0 = 0;
  logic stall_prev = 0;
  logic [31:0] stall_res = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    addsub_pipe_sat_if #(.N(32)) bus ();
    assign bus.in_valid  = in_valid && en[g];
    assign bus.op        = op;
    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.out_ready = out_ready;
    assign rdy_v[g]      = bus.in_ready;
    assign ov[g]         = bus.out_valid;
    assign ofl[g]        = bus.ovf;
    assign cyl[g]        = bus.carry;
    assign rv[g]         = bus.result;
    addsub_pipe_sat #(.N(32), .STAGES(STG[g]), .SAT(SATV[g])) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus_io  (bus)
    );
    always @(negedge clk)
      if (bus.out_valid && out_ready) q[g].push_back('{bus.result, bus.ovf, bus.carry, cyc});
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask
  // occupancy model of the STAGES=2 unit: in_ready may only drop when both stages hold data and the consumer stalls
  always @(negedge clk) begin
    if (!reset_n) begin
      occ = 0;
      stall_prev = 0;
    end else begin
      chk("in_ready", rdy_v[0], !(occ == 2 && !out_ready));
      if (stall_prev) chk("stall_hold", rv[0], stall_res);
      stall_prev = ov[0] && !out_ready;
      stall_res  = rv[0];
      occ = occ + int'(in_valid && rdy_v[0]) - int'(ov[0] && out_ready);
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_on) begin
      out_ready = pat[ph];
      ph = (ph + 1) % 4;
    end
  end
  task automatic send(input op_e o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    in_valid = 1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    while (!rdy_v[0] && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("accept", rdy_v[0], 1);
    last_acc = cyc;
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_q(input int d, input int n);
    int k = 0;
    while (q[d].size() < n && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("q_count", q[d].size(), n);
  endtask
  task automatic pop_chk(input string tag, input int d, input logic [31:0] r, input logic o, input logic c, input int t);
    rec_t e;
    chk({tag, ":have"}, q[d].size() != 0, 1);
    if (q[d].size() != 0) begin
      e = q[d].pop_front();
      chk(tag, e.r, r);
      chk({tag, ":ovf"}, e.o, o);
      chk({tag, ":cy"}, e.c, c);
      if (t >= 0) chk({tag, ":lat"}, e.t, t);
    end
  endtask
  task automatic do_reset();
    reset_n = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int d = 0; d < 4; d++) q[d].delete();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end
  initial begin
    #2 reset_n = 0;
    #3;
    chk("rst_valid", ov[0], 0);
    chk("rst_result", rv[0], 0);
    chk("rst_ovf", ofl[0], 0);
    chk("rst_carry", cyl[0], 0);
    chk("rst_in_ready", rdy_v[0], 1);
    do_reset();
    en = 4'b0011;
    send(OP_ADD, 5, 7);
    t0 = last_acc;
    send(OP_SUB, 3, 10);
    send(OP_ADD, 32'h7FFF_FFFF, 1);
    send(OP_SUB, 32'h8000_0000, 1);
    send(OP_ADD, 32'hFFFF_FFFF, 1);
    wait_q(0, 5);
    wait_q(1, 5);
    pop_chk("add", 0, 12, 0, 0, t0 + 2);
    pop_chk("add_w", 1, 12, 0, 0, t0 + 2);
    pop_chk("sub", 0, 32'hFFFF_FFF9, 0, 1, t0 + 3);
    pop_chk("sub_w", 1, 32'hFFFF_FFF9, 0, 1, t0 + 3);
    pop_chk("sat_hi", 0, 32'h7FFF_FFFF, 1, 0, -1);
    pop_chk("wrap_hi", 1, 32'h8000_0000, 1, 0, -1);
    pop_chk("sat_lo", 0, 32'h8000_0000, 1, 0, -1);
    pop_chk("wrap_lo", 1, 32'h7FFF_FFFF, 1, 0, -1);
    pop_chk("add_carry", 0, 0, 0, 1, -1);
    pop_chk("add_carry_w", 1, 0, 0, 1, -1);
    do_reset();
    en = 4'b0001;
    send(OP_ACC_LOAD, 10, 32'h0000_DEAD);
    send(OP_ACC, 5, 32'h0001_2345);
    send(OP_ACC, 32'hFFFF_FFFD, 32'h7FFF_0000);
    send(OP_ADD, 1, 1);
    send(OP_ACC, 1, 0);
    wait_q(0, 5);
    pop_chk("acc_load", 0, 10, 0, 0, -1);
    pop_chk("acc_p5", 0, 15, 0, 0, -1);
    pop_chk("acc_m3", 0, 12, 0, 1, -1);
    pop_chk("acc_add", 0, 2, 0, 0, -1);
    pop_chk("acc_p1", 0, 13, 0, 0, -1);
    do_reset();
    ph = 0;
    bp_on = 1;
    for (int i = 1; i <= 8; i++) send(OP_ADD, 32'(i), 0);
    wait_q(0, 8);
    bp_on = 0;
    out_ready = 1;
    idle(4);
    chk("bp_count", q[0].size(), 8);
    for (int i = 1; i <= 8; i++) pop_chk("bp_order", 0, 32'(i), 0, 0, -1);
    do_reset();
    en = 4'b1101;
    for (int i = 0; i < 16; i++) begin
      send(OP_ADD, 32'(100 + i), 0);
      if (i == 0) t0 = last_acc;
    end
    for (int d = 0; d < 4; d++)
      if (en[d]) begin
        wait_q(d, 16);
        for (int i = 0; i < 16; i++) pop_chk("thru", d, 32'(100 + i), 0, 0, t0 + i + STG[d]);
      end
    do_reset();
    en = 4'b0001;
    send(OP_ACC_LOAD, 10, 0);
    send(OP_ACC, 5, 0);
    wait_q(0, 2);
    pop_chk("pre_load", 0, 10, 0, 0, -1);
    pop_chk("pre_acc", 0, 15, 0, 0, -1);
    out_ready = 0;
    send(OP_ADD, 1, 2);
    send(OP_ADD, 3, 4);
    chk("pre_rst_valid", ov[0], 1);
    chk("pre_rst_in_ready", rdy_v[0], 0);
    #1 reset_n = 0;
    #1;
    chk("async_valid", ov[0], 0);
    chk("async_result", rv[0], 0);
    @(negedge clk);
    reset_n = 1;
    out_ready = 1;
    @(posedge clk);
    #1;
    send(OP_ACC, 4, 0);
    wait_q(0, 1);
    pop_chk("post_rst_acc", 0, 4, 0, 0, -1);
    idle(5);
    chk("post_rst_extra", q[0].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
